demux_sched: RTL and testbench
==============================

# demux_sched

Round-robin scheduler that shares a single input stream among four consumers behind the 1-to-4 demultiplexer. It grants one consumer at a time for a bounded burst and drives the demux `selector` from the grant. It also moves data words with a valid/ready handshake and inserts a one-cycle guard gap between grants so the demux output never switches in the middle of a transfer.

## Interface
Parameters:
- `W`, 1: data width of the stream.
- `BURST`, 4: maximum transfers per grant (1..255).
- `TIMEOUT`, 16: idle-cycle limit per grant; used only with `DEMUX_SCHED_TIMEOUT_EN` (1..255).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `port_req`  in  4  consumer n wants data.
- `out_ready`  in  4  consumer n can accept a word this cycle.
- `in_valid`  in  1  source word valid.
- `in_data`  in  W  source word.
- `in_ready`  out  1  scheduler accepts the source word.
- `out_valid`  out  1  word on `out_data` is valid for the granted port.
- `out_data`  out  W  word routed to the demux `signal` input.
- `sel`  out  2  demux selector, registered.
- `grant`  out  4  one-hot grant, registered; 0 when no grant.
- `busy`  out  1  high in XFER or GAP.

## Operation
- States: IDLE, XFER, GAP.
- IDLE:
  - If `port_req != 0`, pick the first requesting port, searching from `last+1` mod 4 upward with wrap.
  - Register `sel` and `grant` for that port, set `last` to it, clear `cnt`, and go to XFER.
- XFER:
  - `in_ready = out_ready[sel]`.
  - `out_valid = in_valid`.
  - `out_data = in_data`. These three are combinational.
  - A transfer occurs when `in_valid & in_ready`; each transfer increments `cnt` (8-bit).
- XFER exits to GAP when either:
  - a transfer occurs with `cnt == BURST-1`, or
  - `port_req[sel] == 0` and no transfer occurs in that cycle.
  - A transfer in the same cycle the request drops still completes, and the grant continues to the next cycle's check.
- GAP:
  - `grant = 0`, `in_ready = 0`, `out_valid = 0`.
  - `sel` holds its last value.
  - Next state is IDLE.
- Outside XFER: `in_ready = 0`, `out_valid = 0`, `out_data = 0`.
- Requests arriving during XFER or GAP wait for arbitration in IDLE.
- A port that just finished has lowest priority in the next IDLE evaluation.
- Reset values: state IDLE, `sel = 0`, `grant = 0`, `last = 3` (port 0 has first priority), `cnt = 0`, idle counter 0.
  - All outputs are therefore 0 during and after reset.
  - Reset asserted in XFER drops the grant immediately (asynchronously). The in-flight word is not accepted.

## Timing
- `port_req` rising in IDLE at cycle t: `grant` and `sel` are valid at t+1, and the first transfer is possible at t+1.
- Burst end at cycle t: GAP at t+1, IDLE at t+2, next grant at t+3. Back-to-back grants are therefore at most 1 per `BURST+2` cycles.
- `sel` changes only on the IDLE→XFER edge, never during XFER or GAP.
- Source backpressure: `in_valid = 0` in XFER holds the grant with no count change (unlimited unless the timeout is compiled in).
- Consumer backpressure: `out_ready[sel] = 0` stalls without a count change. `out_ready` of other ports is ignored.
- Simultaneous requests from all 4 ports with continuous traffic: service order follows strict rotation 0,1,2,3,0,…

## Configuration
- `DEMUX_SCHED_TIMEOUT_EN` defined:
  - An 8-bit idle counter clears on entry to XFER and on every transfer.
  - It increments on each XFER cycle without a transfer.
  - On reaching `TIMEOUT`, XFER exits to GAP at the next edge, the same as a burst end.
- Not defined:
  - No idle counter exists and the `TIMEOUT` parameter is unused.
  - A grant holds indefinitely while `port_req[sel]` stays high.

## Test plan
- Reset, then `port_req = 4'b0100` with `in_valid = 1` and `out_ready = 4'hF` → `grant = 4'b0100` and `sel = 2` one cycle after the request. Exactly 4 transfers follow, then GAP, IDLE and a regrant to port 2 at cycle t+7 (BURST=4).
- `port_req = 4'hF` with continuous valid/ready → grant sequence 0,1,2,3,0, each grant exactly 4 transfers. `sel` is stable throughout each XFER and GAP.
- Port 1 granted; drop `out_ready[1]` for 3 cycles mid-burst → `in_ready = 0`, `cnt` frozen, and the burst resumes with the total still 4 transfers.
- Port 3 granted; drop `port_req[3]` after 2 transfers with `in_valid = 0` → GAP next cycle, and `grant` reaches 0 two transfers early.
- Assert `rst` during XFER → `grant`, `in_ready`, `out_valid` and `sel` go to 0 without waiting for a clock edge. After release with `port_req = 4'hF`, port 0 is granted first.
- With `DEMUX_SCHED_TIMEOUT_EN` and TIMEOUT=16: port 0 granted, `in_valid = 0` held → grant released after 16 stall cycles. Without the macro the grant persists for 100 cycles.

Source files
------------

// File: rtl/demux_sched_if.sv
// Stream/demux handshake bundle shared by the round-robin scheduler and its environment.
// master = scheduler side; slave = source, consumers and requesters.
interface demux_sched_if #(
  parameter int W = 1
);
  logic [3:0]   port_req;
  logic [3:0]   out_ready;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   sel;
  logic [3:0]   grant;
  logic         busy;

  modport master (
    input  port_req, out_ready, in_valid, in_data,
    output in_ready, out_valid, out_data, sel, grant, busy
  );

  modport slave (
    output port_req, out_ready, in_valid, in_data,
    input  in_ready, out_valid, out_data, sel, grant, busy
  );
endinterface

// File: rtl/demux_sched.sv
// Round-robin 1-to-4 demux scheduler: grant/sel registered 1 cycle after a request, data path combinational,
// burst capped at BURST, one-cycle guard gap; consumer/source stalls freeze the count (DEMUX_SCHED_TIMEOUT_EN adds an idle timeout).
module demux_sched #(
  parameter int W       = 1,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  demux_sched_if.master  bus
);
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t     state;
  logic [1:0] sel_q;
  logic [3:0] grant_q;
  logic [1:0] last;
  logic [7:0] cnt;

  logic       in_xfer;
  logic       fire;
  logic       burst_done;
  logic       req_gone;
  logic       stop;
  logic       found;
  logic [1:0] pick;
  logic [1:0] idx;

  assign in_xfer = (state == XFER);

  assign bus.in_ready  = in_xfer & bus.out_ready[sel_q];
  assign bus.out_valid = in_xfer & bus.in_valid;
  assign bus.out_data  = in_xfer ? bus.in_data : '0;
  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state != IDLE);

  assign fire       = bus.in_valid & bus.in_ready;
  assign burst_done = fire & (cnt == 8'(BURST - 1));
  // A transfer in the same cycle the request drops still counts; the drop is seen next cycle.
  assign req_gone   = ~fire & ~bus.port_req[sel_q];

`ifdef DEMUX_SCHED_TIMEOUT_EN
  logic [7:0] idle_cnt;
  logic       timed_out;

  // Exit on the edge where the idle count reaches TIMEOUT.
  assign timed_out = ~fire & (idle_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= 8'd0;
    end else if (state == IDLE || fire) begin
      idle_cnt <= 8'd0;
    end else if (in_xfer) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end

  assign stop = burst_done | req_gone | timed_out;
`else
  assign stop = burst_done | req_gone;
`endif

  // Search starts just after the last winner, so that port has lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = last;
    idx   = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && bus.port_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel_q   <= 2'd0;
      grant_q <= 4'd0;
      last    <= 2'd3;
      cnt     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel_q   <= pick;
            grant_q <= 4'b0001 << pick;
            last    <= pick;
            cnt     <= 8'd0;
            state   <= XFER;
          end
        end
        XFER: begin
          if (fire) begin
            cnt <= cnt + 8'd1;
          end
          if (stop) begin
            grant_q <= 4'd0;
            state   <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          grant_q <= 4'd0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_demux_sched.sv
// Randomized bench for demux_sched: a grant-level reference model checked every cycle, plus directed literal checks.
module tb_demux_sched;
  localparam int W       = 8;
  localparam int BURST   = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  demux_sched_if #(.W(W)) bus ();

  demux_sched #(.W(W), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner of the current grant (-1 none), transfers so far, guard-gap pending, rotation pointer.
  int m_own  = -1;
  int m_sent = 0;
  int m_gap  = 0;
  int m_last = 3;
  int m_sel  = 0;
  int m_idle = 0;
  int q_own[$];
  int q_len[$];

  always @(negedge clk) begin
    if (rst) begin
      m_own = -1; m_sent = 0; m_gap = 0; m_last = 3; m_sel = 0; m_idle = 0;
      chk("rst_outputs", {bus.grant, bus.sel, bus.in_ready, bus.out_valid, bus.busy, bus.out_data},
          {4'd0, 2'd0, 1'b0, 1'b0, 1'b0, {W{1'b0}}});
    end else begin
      logic granted;
      logic fire;
      logic ended;
      granted = (m_own >= 0);
      chk("grant", bus.grant, granted ? (4'b0001 << m_own) : 4'd0);
      chk("sel", bus.sel, m_sel);
      chk("busy", bus.busy, granted || (m_gap != 0));
      chk("in_ready", bus.in_ready, granted && bus.out_ready[m_own]);
      chk("out_valid", bus.out_valid, granted && bus.in_valid);
      chk("out_data", bus.out_data, granted ? bus.in_data : '0);
      if (granted) begin
        fire = bus.in_valid && bus.out_ready[m_own];
        if (fire) m_sent++;
        m_idle = fire ? 0 : m_idle + 1;
        ended = (fire && m_sent == BURST) || (!fire && !bus.port_req[m_own]);
`ifdef DEMUX_SCHED_TIMEOUT_EN
        if (m_idle == TIMEOUT) ended = 1'b1;
`endif
        if (ended) begin
          q_own.push_back(m_own);
          q_len.push_back(m_sent);
          m_own = -1;
          m_gap = 1;
        end
      end else if (m_gap != 0) begin
        m_gap = 0;
      end else begin
        for (int i = 1; i <= 4; i++) begin
          int p;
          p = (m_last + i) % 4;
          if (m_own < 0 && bus.port_req[p]) begin
            m_own = p; m_last = p; m_sel = p; m_sent = 0; m_idle = 0;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] req, input logic vld, input logic [3:0] rdy);
    bus.port_req  = req;
    bus.in_valid  = vld;
    bus.out_ready = rdy;
    bus.in_data   = W'($urandom);
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    drive(4'd0, 1'b0, 4'd0);
    repeat (2) cyc();
    rst = 1'b0;
    q_own.delete();
    q_len.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_g [7];
    drive(4'd0, 1'b0, 4'd0);
    #1;
    chk("reset_grant", bus.grant, 4'd0);
    chk("reset_sel", bus.sel, 2'd0);
    chk("reset_busy", bus.busy, 1'b0);
    do_reset();

    // Single requester on port 2: 4 transfers, gap, idle, regrant at t+7.
    drive(4'b0100, 1'b1, 4'hF);
    exp_g = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100};
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("p2_grant_t%0d", k + 1), bus.grant, exp_g[k]);
      if (k == 0) chk("p2_sel", bus.sel, 2'd2);
      bus.in_data = W'($urandom);
    end
    chk("p2_burst_len", (q_len.size() > 0) ? q_len[0] : -1, 4);

    // All four requesting: strict rotation, full bursts.
    do_reset();
    drive(4'hF, 1'b1, 4'hF);
    repeat (34) begin
      cyc();
      bus.in_data = W'($urandom);
    end
    chk("rot_count", q_own.size() >= 5, 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rot_owner%0d", k), (q_own.size() > k) ? q_own[k] : -1, k % 4);
      chk($sformatf("rot_len%0d", k), (q_len.size() > k) ? q_len[k] : -1, BURST);
    end

    // Consumer backpressure on port 1 mid-burst; other ready bits must be ignored.
    do_reset();
    drive(4'b0010, 1'b1, 4'hF);
    cyc();
    cyc();
    bus.out_ready = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", bus.in_ready, 1'b0);
      cyc();
    end
    bus.out_ready = 4'hF;
    repeat (4) cyc();
    chk("stall_owner", (q_own.size() > 0) ? q_own[0] : -1, 1);
    chk("stall_len", (q_len.size() > 0) ? q_len[0] : -1, BURST);

    // Port 3 drops its request after 2 transfers with the source idle.
    do_reset();
    drive(4'b1000, 1'b1, 4'hF);
    cyc();
    cyc();
    cyc();
    drive(4'b0000, 1'b0, 4'hF);
    cyc();
    chk("drop_grant", bus.grant, 4'd0);
    chk("drop_busy_gap", bus.busy, 1'b1);
    chk("drop_len", (q_len.size() > 0) ? q_len[0] : -1, 2);

    // Asynchronous reset in XFER on port 2, then port 0 wins first after release.
    do_reset();
    drive(4'b0100, 1'b1, 4'hF);
    cyc();
    cyc();
    chk("pre_rst_grant", bus.grant, 4'b0100);
    rst = 1'b1;
    #1;
    chk("async_rst", {bus.grant, bus.sel, bus.in_ready, bus.out_valid}, 8'd0);
    cyc();
    drive(4'hF, 1'b1, 4'hF);
    rst = 1'b0;
    cyc();
    chk("post_rst_first", bus.grant, 4'b0001);

    // Long source stall on port 0.
    do_reset();
    drive(4'b0001, 1'b0, 4'hF);
    repeat (101) cyc();
`ifdef DEMUX_SCHED_TIMEOUT_EN
    chk("timeout_release", (q_len.size() > 0) ? q_len[0] : -1, 0);
`else
    chk("no_timeout_grant", bus.grant, 4'b0001);
    chk("no_timeout_log", q_own.size(), 0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0)
        bus.port_req = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      bus.in_data   = W'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
